// File: rtl/display_scan_driver.sv
// display_scan_driver
//   Drives a 6-digit multiplexed common-anode style 7-segment display and a PM lamp
//   from the binary time outputs of the clock core. At every frame start the time is
//   snapshotted and converted to BCD by a repeated-subtract FSM. All six digits and
//   the PM lamp are committed together. While any buzzer sounds, the whole display
//   blinks.
//
// Parameters
//   ScanDiv   clk cycles per digit slot (>= 8)
//   BlinkDiv  clk cycles per blink half-period (>= 2)
//
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   display_hour_i        binary hour (0-23 or 1-12)
//   display_min_i         binary minutes
//   display_sec_i         binary seconds
//   current_24_hour_i     24-hour value, used for PM detection
//   hour_format_i         1 = 12-hour mode, 0 = 24-hour mode
//   alarm_buzzer_i        alarm active
//   timer_buzzer_i        timer expired
//   seg_n_o               active-low segments, bit0=a ... bit6=g
//   dig_en_n_o            active-low one-hot digit enable, bit0=sec units, bit5=hour tens
//   pm_led_o              PM indicator
//   frame_start_o         one-cycle pulse at the start of each scan frame
//
// Optional feature
//   LEADING_ZERO_BLANK_EN: in 12-hour mode, a committed hour tens digit of 0 keeps
//   digit 5 dark for its whole slot.

module display_scan_driver #(
  parameter int unsigned ScanDiv  = 1000,
  parameter int unsigned BlinkDiv = 250000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] display_hour_i,
  input  logic [7:0] display_min_i,
  input  logic [7:0] display_sec_i,
  input  logic [7:0] current_24_hour_i,
  input  logic       hour_format_i,
  input  logic       alarm_buzzer_i,
  input  logic       timer_buzzer_i,
  output logic [6:0] seg_n_o,
  output logic [5:0] dig_en_n_o,
  output logic       pm_led_o,
  output logic       frame_start_o
);

  localparam int unsigned PrescW = (ScanDiv > 1) ? $clog2(ScanDiv) : 1;
  localparam int unsigned BlinkW = (BlinkDiv > 1) ? $clog2(BlinkDiv) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(ScanDiv - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BlinkDiv - 1);

  typedef enum logic [2:0] {
    StIdle,
    StConvSec,
    StConvMin,
    StConvHour,
    StCommit
  } state_e;

  function automatic logic [6:0] sat99(input logic [7:0] v);
    return (v > 8'd99) ? 7'd99 : v[6:0];
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Scan timing
  logic [PrescW-1:0] presc_q, presc_d;
  logic [2:0]        slot_q, slot_d;
  logic              frame_tick;

  // Conversion
  state_e          state_q, state_d;
  logic [6:0]      work_q, work_d;
  logic [3:0]      tens_q, tens_d;
  logic [6:0]      min_snap_q, min_snap_d;
  logic [6:0]      hour_snap_q, hour_snap_d;
  logic            pm_snap_q, pm_snap_d;
  logic [5:0][3:0] pend_q, pend_d;
  logic [5:0][3:0] bank_q, bank_d;
  logic            pm_q, pm_d;
`ifdef LEADING_ZERO_BLANK_EN
  logic            fmt_snap_q, fmt_snap_d;
  logic            fmt_q, fmt_d;
`endif

  // Blink
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_on_q, blink_on_d;
  logic              buzz;

  // Registered outputs
  logic [6:0] seg_n_q, seg_n_d;
  logic [5:0] dig_en_n_q, dig_en_n_d;
  logic       pm_led_q;
  logic       frame_start_q;
  logic [3:0] cur_digit;
  logic       hide_slot;

  assign frame_tick = (slot_q == 3'd0) && (presc_q == '0);

  always_comb begin
    presc_d = presc_q + 1'b1;
    slot_d  = slot_q;
    if (presc_q == PrescLast) begin
      presc_d = '0;
      slot_d  = (slot_q == 3'd5) ? 3'd0 : slot_q + 3'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    tens_d      = tens_q;
    min_snap_d  = min_snap_q;
    hour_snap_d = hour_snap_q;
    pm_snap_d   = pm_snap_q;
    pend_d      = pend_q;
    bank_d      = bank_q;
    pm_d        = pm_q;
`ifdef LEADING_ZERO_BLANK_EN
    fmt_snap_d  = fmt_snap_q;
    fmt_d       = fmt_q;
`endif
    unique case (state_q)
      StIdle: begin
        // A frame start that arrives mid-conversion is simply ignored.
        if (frame_tick) begin
          work_d      = sat99(display_sec_i);
          tens_d      = '0;
          min_snap_d  = sat99(display_min_i);
          hour_snap_d = sat99(display_hour_i);
          pm_snap_d   = hour_format_i & (current_24_hour_i >= 8'd12);
`ifdef LEADING_ZERO_BLANK_EN
          fmt_snap_d  = hour_format_i;
`endif
          state_d     = StConvSec;
        end
      end
      StConvSec: begin
        if (work_q >= 7'd10) begin
          work_d = work_q - 7'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          pend_d[0] = work_q[3:0];
          pend_d[1] = tens_q;
          work_d    = min_snap_q;
          tens_d    = '0;
          state_d   = StConvMin;
        end
      end
      StConvMin: begin
        if (work_q >= 7'd10) begin
          work_d = work_q - 7'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          pend_d[2] = work_q[3:0];
          pend_d[3] = tens_q;
          work_d    = hour_snap_q;
          tens_d    = '0;
          state_d   = StConvHour;
        end
      end
      StConvHour: begin
        if (work_q >= 7'd10) begin
          work_d = work_q - 7'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          pend_d[4] = work_q[3:0];
          pend_d[5] = tens_q;
          tens_d    = '0;
          state_d   = StCommit;
        end
      end
      StCommit: begin
        // Digits and lamp switch together so a frame never shows a torn time.
        bank_d  = pend_q;
        pm_d    = pm_snap_q;
`ifdef LEADING_ZERO_BLANK_EN
        fmt_d   = fmt_snap_q;
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign buzz = alarm_buzzer_i | timer_buzzer_i;

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_on_d  = blink_on_q;
    if (!buzz) begin
      // Clearing here guarantees a fresh buzzer always starts visible.
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end
  end

  always_comb begin
    cur_digit = '0;
    case (slot_q)
      3'd0:    cur_digit = bank_q[0];
      3'd1:    cur_digit = bank_q[1];
      3'd2:    cur_digit = bank_q[2];
      3'd3:    cur_digit = bank_q[3];
      3'd4:    cur_digit = bank_q[4];
      3'd5:    cur_digit = bank_q[5];
      default: cur_digit = '0;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign hide_slot = (slot_q == 3'd5) && (bank_q[5] == 4'd0) && fmt_q;
`else
  assign hide_slot = 1'b0;
`endif

  always_comb begin
    seg_n_d    = blink_on_q ? seg7(cur_digit) : 7'h7F;
    dig_en_n_d = ~(6'b1 << slot_q);
    // First cycle of each slot is dark so the previous digit cannot ghost.
    if (!blink_on_q || (presc_q == '0) || hide_slot) begin
      dig_en_n_d = 6'h3F;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q       <= '0;
      slot_q        <= '0;
      state_q       <= StIdle;
      work_q        <= '0;
      tens_q        <= '0;
      min_snap_q    <= '0;
      hour_snap_q   <= '0;
      pm_snap_q     <= 1'b0;
      pend_q        <= '0;
      bank_q        <= '0;
      pm_q          <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      fmt_snap_q    <= 1'b0;
      fmt_q         <= 1'b0;
`endif
      blink_cnt_q   <= '0;
      blink_on_q    <= 1'b1;
      seg_n_q       <= 7'h7F;
      dig_en_n_q    <= 6'h3F;
      pm_led_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      slot_q        <= slot_d;
      state_q       <= state_d;
      work_q        <= work_d;
      tens_q        <= tens_d;
      min_snap_q    <= min_snap_d;
      hour_snap_q   <= hour_snap_d;
      pm_snap_q     <= pm_snap_d;
      pend_q        <= pend_d;
      bank_q        <= bank_d;
      pm_q          <= pm_d;
`ifdef LEADING_ZERO_BLANK_EN
      fmt_snap_q    <= fmt_snap_d;
      fmt_q         <= fmt_d;
`endif
      blink_cnt_q   <= blink_cnt_d;
      blink_on_q    <= blink_on_d;
      seg_n_q       <= seg_n_d;
      dig_en_n_q    <= dig_en_n_d;
      pm_led_q      <= pm_q;
      frame_start_q <= frame_tick;
    end
  end

  assign seg_n_o       = seg_n_q;
  assign dig_en_n_o    = dig_en_n_q;
  assign pm_led_o      = pm_led_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver (ScanDiv=8, BlinkDiv=16).
// Expected per-slot patterns are pushed to a queue when a time is driven and popped
// as each slot of the checked frame is scanned out.

module tb_display_scan_driver;

  localparam int unsigned ScanDiv  = 8;
  localparam int unsigned BlinkDiv = 16;
  localparam int          Frame    = 6 * ScanDiv;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [7:0] display_hour_i, display_min_i, display_sec_i, current_24_hour_i;
  logic       hour_format_i, alarm_buzzer_i, timer_buzzer_i;
  logic [6:0] seg_n_o;
  logic [5:0] dig_en_n_o;
  logic       pm_led_o, frame_start_o;

  int n_checks = 0;
  int n_errors = 0;

  // bit7 = slot kept dark, [6:0] = expected segments
  logic [7:0] cur_exp [6];
  logic       exp_pm;
  logic [7:0] sb_q [$];

  always #5 clk_i = ~clk_i;

  display_scan_driver #(
    .ScanDiv (ScanDiv),
    .BlinkDiv(BlinkDiv)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .display_hour_i   (display_hour_i),
    .display_min_i    (display_min_i),
    .display_sec_i    (display_sec_i),
    .current_24_hour_i(current_24_hour_i),
    .hour_format_i    (hour_format_i),
    .alarm_buzzer_i   (alarm_buzzer_i),
    .timer_buzzer_i   (timer_buzzer_i),
    .seg_n_o          (seg_n_o),
    .dig_en_n_o       (dig_en_n_o),
    .pm_led_o         (pm_led_o),
    .frame_start_o    (frame_start_o)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " seg"}, 32'(seg_n_o), 32'h7F);
    chk({tag, " dig"}, 32'(dig_en_n_o), 32'h3F);
    chk({tag, " pm"}, 32'(pm_led_o), 32'h0);
    chk({tag, " fs"}, 32'(frame_start_o), 32'h0);
  endtask

  // Drive a time and rebuild the expected display model.
  task automatic set_time(input int h, input int m, input int s, input int c24, input bit fmt);
    int hs, ms, ss;
    display_hour_i    = 8'(h);
    display_min_i     = 8'(m);
    display_sec_i     = 8'(s);
    current_24_hour_i = 8'(c24);
    hour_format_i     = fmt;
    hs = (h > 99) ? 99 : h;
    ms = (m > 99) ? 99 : m;
    ss = (s > 99) ? 99 : s;
    cur_exp[0] = {1'b0, seg_of(ss % 10)};
    cur_exp[1] = {1'b0, seg_of(ss / 10)};
    cur_exp[2] = {1'b0, seg_of(ms % 10)};
    cur_exp[3] = {1'b0, seg_of(ms / 10)};
    cur_exp[4] = {1'b0, seg_of(hs % 10)};
    cur_exp[5] = {1'b0, seg_of(hs / 10)};
`ifdef LEADING_ZERO_BLANK_EN
    if (fmt && (hs / 10 == 0)) cur_exp[5][7] = 1'b1;
`endif
    exp_pm = fmt && (c24 >= 12);
  endtask

  task automatic push_exp;
    for (int i = 0; i < 6; i++) sb_q.push_back(cur_exp[i]);
  endtask

  // Called on a frame-start sample; ends on the next frame-start sample.
  task automatic skip(input int frames);
    repeat (frames * Frame) tick;
    chk("frame align", 32'(frame_start_o), 32'h1);
  endtask

  // Check one full frame against the scoreboard, optionally changing seconds mid-frame.
  task automatic run_frame(input int chg_at, input logic [7:0] chg_sec);
    logic [7:0] e;
    logic [5:0] exp_dig;
    int slot, p;
    e = 8'h00;
    for (int j = 0; j < Frame; j++) begin
      if (j > 0) tick;
      slot = j / ScanDiv;
      p    = j % ScanDiv;
      if (j == chg_at) display_sec_i = chg_sec;
      if (p == 0) begin
        chk($sformatf("ghost s%0d", slot), 32'(dig_en_n_o), 32'h3F);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $error("FAIL scoreboard empty: observed 0 entries expected 1");
        end else begin
          e = sb_q.pop_front();
        end
      end else if (e[7]) begin
        chk($sformatf("blank s%0d", slot), 32'(dig_en_n_o), 32'h3F);
      end else begin
        exp_dig = ~(6'b1 << slot);
        chk($sformatf("dig s%0d", slot), 32'(dig_en_n_o), 32'(exp_dig));
        chk($sformatf("seg s%0d", slot), 32'(seg_n_o), 32'(e[6:0]));
      end
    end
    chk("pm", 32'(pm_led_o), 32'(exp_pm));
    tick;
    chk("frame start", 32'(frame_start_o), 32'h1);
  endtask

  // Buzzer run starting on a frame-start sample, with a small blink-phase model.
  task automatic blink_seq(input bit tmr, input int total, input int t_on, input int t_off,
                           input int t_on2, input int t_off2);
    int  m_cnt, fo, slot, p;
    bit  m_on, b, exp_dark;
    logic [5:0] exp_dig;
    m_cnt = 0;
    m_on  = 1'b1;
    for (int t = 0; t < total; t++) begin
      b = ((t >= t_on) && (t < t_off)) || ((t >= t_on2) && (t < t_off2));
      alarm_buzzer_i = b && !tmr;
      timer_buzzer_i = b && tmr;
      exp_dark = !m_on;
      if (!b) begin
        m_cnt = 0;
        m_on  = 1'b1;
      end else if (m_cnt == BlinkDiv - 1) begin
        m_cnt = 0;
        m_on  = !m_on;
      end else begin
        m_cnt++;
      end
      tick;
      fo   = (t + 1) % Frame;
      slot = fo / ScanDiv;
      p    = fo % ScanDiv;
      if (exp_dark) begin
        chk($sformatf("blink dark dig t%0d", t), 32'(dig_en_n_o), 32'h3F);
        chk($sformatf("blink dark seg t%0d", t), 32'(seg_n_o), 32'h7F);
      end else if ((p == 0) || cur_exp[slot][7]) begin
        chk($sformatf("blink lit off t%0d", t), 32'(dig_en_n_o), 32'h3F);
      end else begin
        exp_dig = ~(6'b1 << slot);
        chk($sformatf("blink lit dig t%0d", t), 32'(dig_en_n_o), 32'(exp_dig));
        chk($sformatf("blink lit seg t%0d", t), 32'(seg_n_o), 32'(cur_exp[slot][6:0]));
      end
    end
    alarm_buzzer_i = 1'b0;
    timer_buzzer_i = 1'b0;
  endtask

  initial begin
    rst_ni            = 1'b0;
    display_hour_i    = '0;
    display_min_i     = '0;
    display_sec_i     = '0;
    current_24_hour_i = '0;
    hour_format_i     = 1'b0;
    alarm_buzzer_i    = 1'b0;
    timer_buzzer_i    = 1'b0;
    exp_pm            = 1'b0;
    for (int i = 0; i < 6; i++) cur_exp[i] = 8'h00;

    // Reset held with random inputs, then frame_start cadence.
    for (int i = 0; i < 20; i++) begin
      display_hour_i    = 8'($urandom);
      display_min_i     = 8'($urandom);
      display_sec_i     = 8'($urandom);
      current_24_hour_i = 8'($urandom);
      hour_format_i     = 1'($urandom);
      alarm_buzzer_i    = 1'($urandom);
      timer_buzzer_i    = 1'($urandom);
      tick;
      chk_reset_outs("reset");
    end
    alarm_buzzer_i = 1'b0;
    timer_buzzer_i = 1'b0;
    rst_ni = 1'b1;
    for (int t = 1; t <= 2 * Frame + 1; t++) begin
      tick;
      chk($sformatf("fs cadence t%0d", t), 32'(frame_start_o), 32'(t % Frame == 1));
    end

    // 24-hour display, PM lamp stays off.
    set_time(23, 59, 58, 23, 1'b0);
    skip(2);
    push_exp();
    run_frame(-1, 8'd0);

    // 12-hour mode with PM lamp, then a single-digit hour.
    set_time(11, 59, 58, 23, 1'b1);
    skip(2);
    push_exp();
    run_frame(-1, 8'd0);
    set_time(9, 59, 58, 23, 1'b1);
    skip(2);
    push_exp();
    run_frame(-1, 8'd0);

    // Saturation, then an input change mid-frame that must not show until a commit.
    set_time(11, 42, 150, 23, 1'b1);
    skip(2);
    push_exp();
    run_frame(10, 8'd7);
    set_time(11, 42, 7, 23, 1'b1);
    skip(1);
    push_exp();
    run_frame(-1, 8'd0);

    // Blink with alarm, then timer with early release and re-assertion.
    blink_seq(1'b0, 2 * Frame, 0, 64, 0, 0);
    blink_seq(1'b1, 2 * Frame, 0, 24, 30, 70);
    chk("after blink align", 32'(frame_start_o), 32'h1);

    // Reset during conversion discards the partial result.
    set_time(12, 34, 56, 20, 1'b1);
    skip(1);
    repeat (4) tick;
    rst_ni = 1'b0;
    #1;
    chk_reset_outs("mid reset");
    set_time(8, 7, 6, 8, 1'b0);
    repeat (3) begin
      tick;
      chk_reset_outs("mid reset hold");
    end
    rst_ni = 1'b1;
    tick;
    chk("fs after reset", 32'(frame_start_o), 32'h1);
    skip(1);
    push_exp();
    run_frame(-1, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
